// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU sequencing arbiter.
package alu_pkg;

    localparam int W_DEF = 8;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CAP_HI = 3'd4,
        ST_CAP_LO = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus. A request transfers on the cycle req_valid[i] && req_ready[i];
// req_valid must stay high until then. A response transfers when rsp_valid[i] && rsp_ready[i].
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int W = W_DEF
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [3:0]     req_op;
    logic [2*W-1:0] req_x;
    logic [2*W-1:0] req_y;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_err;

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       gidx
);
    logic ptr;

    always_comb begin
        gidx  = ptr;
        grant = 2'b00;
        if (!req[ptr]) begin
            gidx = ~ptr;
        end
        if (req[gidx]) begin
            grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~gidx;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer in front of the 8-bit sequential ALU: arbitrates two requesters,
// drives the X/Y load protocol, captures {hi,lo} and returns the result.
module alu_arbiter import alu_pkg::*; #(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [W-1:0] alu_in,
    output logic [1:0]   alu_op,
    output logic         alu_valid,
    input  logic [W-1:0] alu_o,
    input  logic         alu_ready,
    output logic         busy,
    output state_t       dbg_state
);
    localparam int CW = $clog2(TIMEOUT);

    state_t         state, nxt;
    logic [1:0]     op_q;
    logic [W-1:0]   x_q, y_q, hi_q, lo_q;
    logic [2*W-1:0] result_q;
    logic           err_q;
    logic           gidx_q;
    logic [CW-1:0]  cnt;
    logic [1:0]     grant;
    logic           gidx;
    logic           accept;
    logic           timed_out;
    logic [1:0]     req_ready_c;
    logic [1:0]     rsp_valid_c;

    assign accept    = (state == ST_IDLE) && (|bus.req_valid);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .accept (accept),
        .grant  (grant),
        .gidx   (gidx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            gidx_q   <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= gidx ? bus.req_op[3:2] : bus.req_op[1:0];
                        x_q    <= gidx ? bus.req_x[2*W-1:W] : bus.req_x[W-1:0];
                        y_q    <= gidx ? bus.req_y[2*W-1:W] : bus.req_y[W-1:0];
                        gidx_q <= gidx;
                    end
                end
                ST_LOAD_Y: cnt <= '0;
                ST_WAIT: begin
                    // A late alu_ready on the final cycle still wins over the abort.
                    if (alu_ready) begin
                        hi_q <= alu_o;
                    end else if (timed_out) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CAP_HI: lo_q <= alu_o;
                ST_CAP_LO: begin
                    result_q <= {hi_q, lo_q};
                    err_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt         = state;
        alu_valid   = 1'b0;
        alu_in      = '0;
        alu_op      = '0;
        busy        = 1'b1;
        req_ready_c = 2'b00;
        rsp_valid_c = 2'b00;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                // Gated by rst so no accept pulse is visible while held in reset.
                req_ready_c = grant & {2{rst}};
                if (accept) nxt = ST_LOAD_X;
            end
            ST_LOAD_X: begin
                alu_valid = 1'b1;
                alu_in    = x_q;
                alu_op    = op_q;
                nxt       = ST_LOAD_Y;
            end
            ST_LOAD_Y: begin
                alu_in = y_q;
                alu_op = op_q;
                nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                alu_op = op_q;
                if (alu_ready)      nxt = ST_CAP_HI;
                else if (timed_out) nxt = ST_RESP;
            end
            ST_CAP_HI: nxt = ST_CAP_LO;
            ST_CAP_LO: nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid_c = gidx_q ? 2'b10 : 2'b01;
                if (bus.rsp_ready[gidx_q]) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = result_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Sequencing controller and 2-way round-robin arbiter in front of the 8-bit sequential ALU core.
- Accepts complete operation requests (opcode, operand X, operand Y) from two requesters.
- Drives the ALU load protocol, waits for completion, captures the two result bytes and returns a 16-bit result to the winning requester.
- Sits between the bus-side requesters and the ALU core instance; the ALU core is unchanged.

Parameters:
W, 8, operand width; ALU byte width.
TIMEOUT, 64, maximum cycles in WAIT before an operation is aborted with error.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  2  per-requester request valid; bit i = requester i.
req_ready  out  2  per-requester request accept; one-cycle pulse on accept.
req_op  in  4  opcodes; [2i+1:2i] for requester i.
req_x  in  2*W  operand X; [W*i+W-1:W*i].
req_y  in  2*W  operand Y, same packing.
rsp_valid  out  2  result valid, held until accepted.
rsp_ready  in  2  result accept from requester.
rsp_data  out  2*W  shared result bus {hi,lo}; meaningful only where rsp_valid is set.
rsp_err  out  1  qualifies rsp_data: 1 = timeout abort.
alu_in  out  W  ALU inbus.
alu_op  out  2  ALU op_codes.
alu_valid  out  1  ALU start strobe.
alu_o  in  W  ALU result bus.
alu_ready  in  1  ALU done.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async):
  - state = IDLE, rr_ptr = 0 (requester 0 preferred).
  - All outputs 0: req_ready, rsp_valid, alu_valid, alu_in, alu_op, rsp_data, rsp_err, busy.
- Reset mid-operation: abandons the operation without a response; the ALU shares rst and is cleared with it.
- States: IDLE, LOAD_X, LOAD_Y, WAIT, CAP_HI, CAP_LO, RESP.
- IDLE:
  - If any req_valid is set, the grant goes to the requester at rr_ptr if it is valid, else the other one.
  - Grant cycle: req_ready[g] pulses for one cycle; op/X/Y are latched into internal registers; the granted index is stored.
  - rr_ptr := ~g (the loser has priority next time).
  - Next state LOAD_X.
- LOAD_X (1 cycle): alu_valid=1, alu_in=X, alu_op=op. -> LOAD_Y.
- LOAD_Y (1 cycle): alu_valid=0, alu_in=Y (M load cycle). Timeout counter cleared. -> WAIT.
- WAIT:
  - alu_in=0. Counter increments each cycle.
  - alu_ready=1 -> CAP_HI, and alu_o is captured as hi byte in the same cycle.
  - Counter reaching TIMEOUT-1 without alu_ready -> RESP with rsp_err=1, rsp_data=0.
- CAP_HI (1 cycle): alu_o captured as lo byte. -> CAP_LO.
- CAP_LO (1 cycle): result register = {hi,lo}, rsp_err=0. -> RESP.
- Result byte order: hi byte = A register (presented first), lo byte = Q register (presented next cycle). For add/sub, hi holds the result and lo is don't-care-but-captured.
- RESP:
  - rsp_valid[g]=1; rsp_data and rsp_err stable while valid.
  - rsp_ready[g]=1 -> clear rsp_valid, -> IDLE. rsp_ready on the non-granted bit is ignored.
- Throughput: minimum 6 cycles per operation plus ALU latency. No new grant is issued before return to IDLE.
- Simultaneous req_valid in IDLE: rr_ptr decides. A request arriving during an operation waits; req_valid must stay high until req_ready (no drop required).
- alu_ready asserted in LOAD_X or LOAD_Y is ignored.
- TIMEOUT counter width is clog2(TIMEOUT). It wraps only via the clear in LOAD_Y.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants (3-bit);
  - ALU opcode constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - W default.
- One natural sub-module: rr_arb2 (2-input round-robin grant with pointer update on accept). Everything else stays in one FSM module.

Test Plan:
- Single request: req0 op=2, X=8'h05, Y=8'h03. Expect:
  - req_ready=01 pulse;
  - alu_in=05 with alu_valid, then 03;
  - model returns hi=00, lo=0F;
  - rsp_valid=01, rsp_data=16'h000F, rsp_err=0.
- Simultaneous requests after reset: both req_valid=11. Expect:
  - requester 0 granted first, then requester 1;
  - a third back-to-back pair grants 0 again (alternation);
  - rsp_data is routed to the correct index each time.
- Backpressure: hold rsp_ready=0 for 10 cycles with a pending req1. Expect:
  - rsp_valid and rsp_data stable;
  - no req_ready pulse until rsp accepted.
- Timeout: ALU model never asserts alu_ready. Expect:
  - RESP after TIMEOUT cycles in WAIT with rsp_err=1, rsp_data=0;
  - next request is serviced normally.
- Reset mid-WAIT: drop rst for 1 cycle. Expect:
  - immediate (asynchronous) busy=0 and all outputs 0;
  - no rsp_valid;
  - pending req_valid is granted afresh with rr_ptr=0.
- Spurious alu_ready during LOAD_X: ignored, with the capture occurring only on the WAIT-state alu_ready edge.
